guess_entry_ctrl: RTL and testbench
===================================

Name: guess_entry_ctrl

Overview:
Parametrised successor to the single-mode button/value editor in the top level. It owns the display-mode selector and a cursor-driven multi-digit value editor. On commit it streams the edited digits into video RAM, one entry per cycle, and tracks how many rows are used. Inputs are single-cycle pulses that have already been debounced and edge-detected; outputs drive the segment-display value array, the LEDs and the VIDEORAM write port.

Parameters:
MODES, 5, number of display modes; MODE wraps from MODES-1 to 0
EDIT_MODE, 2, mode in which editing and commit are enabled
DIGITS, 4, digits per guess (1..8)
SYMBOLS, 6, legal digit values 0..SYMBOLS-1 (2..16)
ROWS, 4, guess rows in RAM; RAM holds ROWS*DIGITS entries
VW, 4, digit value width, must satisfy 2^VW >= SYMBOLS
AW, 4, RAM address width, must satisfy 2^AW >= ROWS*DIGITS
DW, 6, RAM data width, must satisfy DW >= VW

Ports:
CLK  in  1  system clock (CLK_PLL domain)
RST_N  in  1  asynchronous active-low reset
MODE_BTN  in  1  pulse: advance mode
SEL_BTN  in  1  pulse: move cursor to the next digit
INC_BTN  in  1  pulse: increment the digit under the cursor
COMMIT_BTN  in  1  pulse: commit the current guess
MODE  out  $clog2(MODES)  current display mode
CURSOR  out  $clog2(DIGITS)  selected digit index
DIGIT_VALS  out  DIGITS*VW  edit buffer, digit i at [i*VW +: VW]
ROW  out  $clog2(ROWS+1)  number of committed rows
BUSY  out  1  high while in WRITE
FULL  out  1  high when ROW==ROWS
RAM_WADDR  out  AW  write address
RAM_WDATA  out  DW  write data, digit value zero-extended
RAM_WEN  out  1  write enable, one cycle per entry

Behaviour:
- Reset (async assert, sync release): MODE=0, CURSOR=0, DIGIT_VALS=0, ROW=0, state=EDIT, BUSY=0, FULL=0, RAM_WEN=0, RAM_WADDR=0, RAM_WDATA=0.
- All outputs are registered. A button effect is visible on the cycle after the pulse.
- MODE_BTN: MODE <= (MODE==MODES-1) ? 0 : MODE+1. This happens in every state and has the highest priority. In the same cycle SEL, INC and COMMIT are ignored.
- States:
  - EDIT: editing and commit are active only when MODE==EDIT_MODE.
  - WRITE: stream the buffer to RAM.
  - FULL: terminal state.
- EDIT, with MODE==EDIT_MODE and no MODE_BTN:
  - Priority COMMIT > SEL > INC. Only one action is taken per cycle.
  - SEL: CURSOR <= (CURSOR==DIGITS-1) ? 0 : CURSOR+1.
  - INC: digit[CURSOR] <= (digit==SYMBOLS-1) ? 0 : digit+1. Wrap is at SYMBOLS, not at 2^VW.
  - COMMIT: latch the buffer into a shadow copy, set idx=0, go to WRITE.
- WRITE:
  - Each cycle: RAM_WEN=1, RAM_WADDR=ROW*DIGITS+idx, RAM_WDATA=shadow[idx], then idx++.
  - After idx DIGITS-1: ROW++, RAM_WEN=0 on the next cycle, CURSOR=0, DIGIT_VALS=0.
  - Next state is FULL if the new ROW==ROWS, else EDIT.
  - Exactly DIGITS consecutive RAM_WEN cycles per commit. The first RAM_WEN cycle is the cycle after the COMMIT pulse.
  - SEL, INC and COMMIT are ignored during WRITE.
  - A MODE change during WRITE does not abort the write.
- FULL: FULL=1. SEL, INC and COMMIT are ignored. MODE_BTN still works. Only reset leaves FULL.
- Outside EDIT_MODE, the edit buffer and CURSOR hold their values across mode changes.
- Reset during WRITE aborts immediately: RAM_WEN=0 at once (async), and the partial row is not counted.

Test Plan:
1. Reset, then 5 MODE_BTN pulses -> MODE goes 1,2,3,4,0. During reset all outputs are 0.
2. In MODE=2, 7 INC_BTN pulses -> digit0 goes 1..5,0,1 (SYMBOLS=6 wrap). 4 SEL_BTN pulses -> CURSOR goes 1,2,3,0.
3. Buffer {3,1,4,5}, ROW=0, COMMIT_BTN -> next 4 cycles RAM_WEN=1 with addr 0,1,2,3 and data 5,4,1,3 per the digit mapping (digit i at addr i). Then ROW=1, DIGIT_VALS=0, BUSY=0.
4. Four commits of {1,2,3,4} -> addrs 0..15 written, ROW=4, FULL=1. A further COMMIT or INC -> no RAM_WEN, buffer unchanged.
5. MODE_BTN and INC_BTN in the same cycle in MODE=2 -> MODE=3, digit unchanged. INC in MODE=3 -> ignored.
6. Assert RST_N low on the 2nd write cycle -> RAM_WEN drops immediately, ROW=0 after release.

Source files
------------

// File: rtl/guess_entry_ctrl.sv
// Display-mode selector plus cursor-driven multi-digit guess editor.
// A commit streams the edited digits into video RAM, one entry per cycle, and counts used rows.
module guess_entry_ctrl #(
  parameter int MODES     = 5,
  parameter int EDIT_MODE = 2,
  parameter int DIGITS    = 4,
  parameter int SYMBOLS   = 6,
  parameter int ROWS      = 4,
  parameter int VW        = 4,
  parameter int AW        = 4,
  parameter int DW        = 6,
  localparam int MW = (MODES  > 1) ? $clog2(MODES)  : 1,
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int RW = $clog2(ROWS + 1),
  localparam int IW = $clog2(DIGITS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 MODE_BTN,
  input  logic                 SEL_BTN,
  input  logic                 INC_BTN,
  input  logic                 COMMIT_BTN,
  output logic [MW-1:0]        MODE,
  output logic [CW-1:0]        CURSOR,
  output logic [DIGITS*VW-1:0] DIGIT_VALS,
  output logic [RW-1:0]        ROW,
  output logic                 BUSY,
  output logic                 FULL,
  output logic [AW-1:0]        RAM_WADDR,
  output logic [DW-1:0]        RAM_WDATA,
  output logic                 RAM_WEN
);

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MW-1:0]        mode_q, mode_d;
  logic [CW-1:0]        cursor_q, cursor_d;
  logic [DIGITS*VW-1:0] vals_q, vals_d;
  logic [DIGITS*VW-1:0] shadow_q, shadow_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 full_q, full_d;
  logic                 wen_q, wen_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [VW-1:0]        cur_digit_s;

  assign cur_digit_s = vals_q[int'(cursor_q)*VW +: VW];

  // Next-state logic: mode stepping always wins; editing only in EDIT while in the edit mode
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cursor_d = cursor_q;
    vals_d   = vals_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    row_d    = row_q;
    busy_d   = busy_q;
    full_d   = full_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (MODE_BTN) begin
      mode_d = (mode_q == MW'(MODES - 1)) ? {MW{1'b0}} : mode_q + MW'(1);
    end else begin
      mode_d = mode_q;
    end

    case (state_q)
      ST_EDIT: begin
        if (!MODE_BTN && (mode_q == MW'(EDIT_MODE))) begin
          if (COMMIT_BTN) begin
            // Entry 0 goes out straight from the live buffer so the first write follows the pulse
            shadow_d = vals_q;
            idx_d    = IW'(1);
            wen_d    = 1'b1;
            waddr_d  = AW'(row_q) * AW'(DIGITS);
            wdata_d  = DW'(vals_q[VW-1:0]);
            busy_d   = 1'b1;
            state_d  = ST_WRITE;
          end else if (SEL_BTN) begin
            cursor_d = (cursor_q == CW'(DIGITS - 1)) ? {CW{1'b0}} : cursor_q + CW'(1);
          end else if (INC_BTN) begin
            vals_d[int'(cursor_q)*VW +: VW] =
              (cur_digit_s == VW'(SYMBOLS - 1)) ? {VW{1'b0}} : cur_digit_s + VW'(1);
          end else begin
            vals_d = vals_q;
          end
        end else begin
          vals_d = vals_q;
        end
      end
      ST_WRITE: begin
        if (idx_q == IW'(DIGITS)) begin
          row_d    = row_q + RW'(1);
          cursor_d = {CW{1'b0}};
          vals_d   = {(DIGITS*VW){1'b0}};
          busy_d   = 1'b0;
          if (row_q == RW'(ROWS - 1)) begin
            full_d  = 1'b1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EDIT;
          end
        end else begin
          wen_d   = 1'b1;
          waddr_d = AW'(row_q) * AW'(DIGITS) + AW'(idx_q);
          wdata_d = DW'(shadow_q[int'(idx_q)*VW +: VW]);
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: begin
        state_d = ST_EDIT;
      end
    endcase
  end

  // State and output registers; reset aborts any write in progress
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_EDIT;
      mode_q   <= {MW{1'b0}};
      cursor_q <= {CW{1'b0}};
      vals_q   <= {(DIGITS*VW){1'b0}};
      shadow_q <= {(DIGITS*VW){1'b0}};
      idx_q    <= {IW{1'b0}};
      row_q    <= {RW{1'b0}};
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      vals_q   <= vals_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign MODE       = mode_q;
  assign CURSOR     = cursor_q;
  assign DIGIT_VALS = vals_q;
  assign ROW        = row_q;
  assign BUSY       = busy_q;
  assign FULL       = full_q;
  assign RAM_WEN    = wen_q;
  assign RAM_WADDR  = waddr_q;
  assign RAM_WDATA  = wdata_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Bench for guess_entry_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_guess_entry_ctrl;
  localparam int MODES = 5, EDIT_MODE = 2, DIGITS = 4, SYMBOLS = 6, ROWS = 4;
  localparam int VW = 4, AW = 4, DW = 6;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic MODE_BTN = 1'b0, SEL_BTN = 1'b0, INC_BTN = 1'b0, COMMIT_BTN = 1'b0;
  logic [2:0]  MODE;
  logic [1:0]  CURSOR;
  logic [15:0] DIGIT_VALS;
  logic [2:0]  ROW;
  logic        BUSY, FULL, RAM_WEN;
  logic [3:0]  RAM_WADDR;
  logic [5:0]  RAM_WDATA;

  guess_entry_ctrl #(.MODES(MODES), .EDIT_MODE(EDIT_MODE), .DIGITS(DIGITS), .SYMBOLS(SYMBOLS),
                     .ROWS(ROWS), .VW(VW), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .MODE_BTN(MODE_BTN), .SEL_BTN(SEL_BTN), .INC_BTN(INC_BTN),
    .COMMIT_BTN(COMMIT_BTN), .MODE(MODE), .CURSOR(CURSOR), .DIGIT_VALS(DIGIT_VALS), .ROW(ROW),
    .BUSY(BUSY), .FULL(FULL), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_WEN(RAM_WEN));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a commit enqueues every pending RAM write plus a row-done marker;
  // one queue item is consumed per clock while the queue is non-empty.
  typedef struct { bit fin; int addr; int data; } wr_t;
  wr_t pend[$];
  int  m_mode, m_cursor, m_row, m_addr, m_data;
  int  m_dig[DIGITS];
  bit  m_full, m_wen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cursor = 0; m_row = 0; m_full = 0; m_wen = 0; m_addr = 0; m_data = 0;
    foreach (m_dig[k]) m_dig[k] = 0;
    pend.delete();
  endtask

  task automatic model_edge(input bit mb, input bit sb, input bit ib, input bit cb);
    int  old_mode;
    wr_t w;
    old_mode = m_mode;
    m_wen = 0;
    if (mb) m_mode = (m_mode + 1) % MODES;
    if (pend.size() == 0 && !m_full && !mb && old_mode == EDIT_MODE) begin
      if (cb) begin
        for (int k = 0; k < DIGITS; k++) pend.push_back('{1'b0, m_row * DIGITS + k, m_dig[k]});
        pend.push_back('{1'b1, 0, 0});
      end else if (sb) begin
        m_cursor = (m_cursor + 1) % DIGITS;
      end else if (ib) begin
        m_dig[m_cursor] = (m_dig[m_cursor] + 1) % SYMBOLS;
      end
    end
    if (pend.size() > 0) begin
      w = pend.pop_front();
      if (w.fin) begin
        m_row++;
        m_cursor = 0;
        foreach (m_dig[k]) m_dig[k] = 0;
        if (m_row == ROWS) m_full = 1;
      end else begin
        m_wen = 1; m_addr = w.addr; m_data = w.data;
      end
    end
  endtask

  function automatic logic [15:0] m_vals();
    logic [15:0] v;
    v = 16'h0000;
    for (int k = 0; k < DIGITS; k++) v[k*VW +: VW] = m_dig[k][VW-1:0];
    return v;
  endfunction

  task automatic compare_all();
    check("mode", MODE, m_mode);
    check("cursor", CURSOR, m_cursor);
    check("digit_vals", DIGIT_VALS, m_vals());
    check("row", ROW, m_row);
    check("busy", BUSY, (pend.size() > 0) ? 1 : 0);
    check("full", FULL, m_full);
    check("ram_wen", RAM_WEN, m_wen);
    if (m_wen) begin
      check("ram_waddr", RAM_WADDR, m_addr);
      check("ram_wdata", RAM_WDATA, m_data);
    end
  endtask

  // Called at posedge+1; drives one set of pulses for exactly one clock edge.
  task automatic step(input bit mb, input bit sb, input bit ib, input bit cb);
    MODE_BTN = mb; SEL_BTN = sb; INC_BTN = ib; COMMIT_BTN = cb;
    @(posedge CLK);
    model_edge(mb, sb, ib, cb);
    #1;
    MODE_BTN = 1'b0; SEL_BTN = 1'b0; INC_BTN = 1'b0; COMMIT_BTN = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check("rst_mode", MODE, 0);
    check("rst_vals", DIGIT_VALS, 0);
    check("rst_row_full_busy", {ROW, FULL, BUSY}, 0);
    check("rst_ram", {RAM_WEN, RAM_WADDR, RAM_WDATA}, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Enter digits d0..d3 starting from a cleared buffer with the cursor at 0.
  task automatic set_buf(input int d0, input int d1, input int d2, input int d3);
    int v[4];
    v = '{d0, d1, d2, d3};
    for (int k = 0; k < DIGITS; k++) begin
      repeat (v[k]) step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  typedef struct { bit m, s, i, c; int e_mode; int e_cur; logic [15:0] e_vals; } vec_t;
  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ed[4];
    int addrs[$];
    for (int m = 1; m <= 7; m++) tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, m % 5, 0, 16'h0000});
    for (int i = 1; i <= 7; i++) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 16'(i % 6)});
    for (int i = 1; i <= 4; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2, i % 4, 16'h0001});

    @(posedge CLK); #1;
    do_reset();
    foreach (tbl[n]) begin
      step(tbl[n].m, tbl[n].s, tbl[n].i, tbl[n].c);
      check("tbl_mode", MODE, tbl[n].e_mode);
      check("tbl_cursor", CURSOR, tbl[n].e_cur);
      check("tbl_vals", DIGIT_VALS, tbl[n].e_vals);
    end

    // Buffer d3..d0 = {3,1,4,5}: expect data 5,4,1,3 at addresses 0..3
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    set_buf(5, 4, 1, 3);
    ed = '{5, 4, 1, 3};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, (k == 0));
      check("commit_wen", RAM_WEN, 1);
      check("commit_addr", RAM_WADDR, k);
      check("commit_data", RAM_WDATA, ed[k]);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("commit_done", {RAM_WEN, BUSY, ROW, DIGIT_VALS}, {1'b0, 1'b0, 3'd1, 16'h0000});

    // Fill all rows, then FULL must block commit and increment
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      set_buf(1, 2, 3, 4);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (RAM_WEN) addrs.push_back(int'(RAM_WADDR));
      for (int k = 0; k < DIGITS; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (RAM_WEN) addrs.push_back(int'(RAM_WADDR));
      end
    end
    check("fill_count", addrs.size(), 16);
    foreach (addrs[n]) check("fill_addr", addrs[n], n);
    check("fill_row_full", {ROW, FULL}, {3'd4, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_commit_wen", RAM_WEN, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_inc_vals", DIGIT_VALS, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("full_mode", MODE, 3);

    // MODE_BTN wins over INC in the same cycle; INC outside the edit mode is ignored
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_mode_vals", {MODE, DIGIT_VALS}, {3'd3, 16'h0001});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("mode3_inc", DIGIT_VALS, 16'h0001);

    // Reset on the second write cycle aborts the row
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    set_buf(1, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_pre_wen", RAM_WEN, 1);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("abort_wen_async", RAM_WEN, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_row", {ROW, BUSY, RAM_WEN}, 0);

    // Randomized traffic against the reference model
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int n = 0; n < 600; n++) begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 0, $urandom_range(0, 29) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
